vending_fsm_param: RTL and testbench
====================================

Name: vending_fsm_param

Overview:
- Parametrised next-generation vending controller: a credit accumulator and a dispense/change sequencer merged into one FSM.
- Adds multi-value coins, N selectable products with a per-product price table, change return, cancel, and overflow rejection.
- Sits behind the clock prescaler; inputs come from debounced user pins, outputs drive status pins.

Parameters:
- CREDIT_W, 5, width of the credit register, coin values, prices and change.
- MAX_CREDIT, 31, highest credit accepted (must be ≤ 2^CREDIT_W-1).
- NUM_PRODUCTS, 4, number of selectable products (≥2).
- PRICE_TABLE, {5'd7,5'd5,5'd3,5'd2}, packed NUM_PRODUCTS*CREDIT_W prices; product 0 in the LSBs.
- DISPENSE_CYCLES, 2, number of cycles dispense stays high (≥1).
- STOCK_INIT, 3, initial per-product stock (used only with STOCK_COUNT_EN).

Ports:
- clk  in  1  system clock (prescaled)
- reset  in  1  synchronous, active-high
- coin_valid  in  1  single-cycle coin-inserted strobe
- coin_value  in  CREDIT_W  coin value, sampled with coin_valid
- buy  in  1  purchase request strobe
- sel  in  $clog2(NUM_PRODUCTS)  product index, sampled with buy
- cancel  in  1  refund request strobe
- credit  out  CREDIT_W  current credit
- dispense  out  1  high while the product is being released
- product  out  $clog2(NUM_PRODUCTS)  index being dispensed; held until the next vend
- change_valid  out  1  single-cycle strobe
- change_amount  out  CREDIT_W  valid with change_valid, else 0
- coin_reject  out  1  single-cycle strobe: coin returned unaccepted
- insufficient  out  1  single-cycle strobe: buy refused for low credit or invalid sel
- busy  out  1  high in VEND or CHANGE
- sold_out  out  1  single-cycle strobe (STOCK_COUNT_EN only)

Behaviour:
- Reset: state=IDLE; credit=0, product=0, every other output 0.
- Reset mid-vend aborts the vend; credit is lost and no change is emitted.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0.
  - VEND: dispense high for DISPENSE_CYCLES cycles.
  - CHANGE: exactly one cycle.
- Input priority per cycle in IDLE/CREDIT: cancel > coin > buy.
- cancel with credit>0 → CHANGE next cycle, change_amount=credit; then credit=0, IDLE.
- cancel with credit==0: ignored.
- Coin handling:
  - coin_valid and credit+coin_value ≤ MAX_CREDIT: credit updates next cycle; state → CREDIT.
  - Sum computed at CREDIT_W+1 bits; a coin that would exceed MAX_CREDIT pulses coin_reject next cycle, credit unchanged.
  - coin_value==0 is accepted as a no-op.
- Same-cycle collisions: a buy together with a coin is dropped silently. A coin together with cancel gets coin_reject.
- buy handling:
  - sel ≥ NUM_PRODUCTS, or credit < PRICE_TABLE[sel]: insufficient pulses next cycle; state unchanged.
  - Otherwise the purchase is accepted: latch price and product=sel, then VEND next cycle.
- VEND: dispense=1 for exactly DISPENSE_CYCLES cycles.
- CHANGE: one cycle with change_valid=1, change_amount=credit-price (0 is allowed, strobe still fires). Next cycle: credit=0, IDLE.
- VEND and CHANGE are uninterruptible except by reset. busy=1 throughout.
  - coin_valid in either state → coin_reject.
  - buy and cancel in either state are ignored.
- All strobes are registered: one cycle after the causing input.

Optional Feature:
- Macro STOCK_COUNT_EN.
- Defined:
  - Per-product stock counters load STOCK_INIT on reset and decrement on VEND entry.
  - A buy of a product with stock 0 pulses sold_out next cycle. No vend; credit is kept. This check takes precedence over the credit check.
- Undefined: unlimited stock; sold_out tied 0; no counter logic.

Decomposition:
- Package vending_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE);
  - a price-extract function;
  - the state encoding width constant.
- One sub-module: vend_stock_bank. It holds the NUM_PRODUCTS stock counters with empty flags and is instantiated only under STOCK_COUNT_EN.

Test Plan:
- Coins 2,1 then buy sel=1 (price 3) → credit 3; dispense high 2 cycles with product=1; change_valid with amount 0; credit returns to 0.
- Coins 5,5 then buy sel=3 (price 7) → dispense; change_amount=3.
- credit=2, buy sel=2 (price 5) → insufficient pulse, credit stays 2. Then cancel → change_amount=2, state IDLE.
- credit=30, coin 5 → coin_reject, credit 30. Coin 1 → credit 31. Coin inserted during VEND → coin_reject, credit unaffected.
- Same cycle cancel+coin 3 with credit 4 → change_amount=4 and coin_reject. Reset asserted in VEND → all outputs 0 next cycle.
- STOCK_COUNT_EN: 3 successful buys of sel=0 with credit 2 each; a 4th buy → sold_out, credit kept at 2.

Source files
------------

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending controller:
//   - STATE_W / state_e : controller state encoding (IDLE, CREDIT, VEND, CHANGE)
//   - PRICE_TBL_MAX_W   : widest packed price table price_at() can accept
//   - price_at()        : pulls one price out of a packed price table
// -----------------------------------------------------------------------------
package vending_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    localparam int PRICE_TBL_MAX_W = 128;

    // Returns the w-bit field at index idx of a packed table (entry 0 in the
    // LSBs), zero-extended to the full table width so callers can compare it
    // without truncating first.
    function automatic logic [PRICE_TBL_MAX_W-1:0] price_at(
        input logic [PRICE_TBL_MAX_W-1:0] tbl,
        input int                         idx,
        input int                         w
    );
        logic [PRICE_TBL_MAX_W-1:0] mask;
        mask = (PRICE_TBL_MAX_W'(1) << w) - PRICE_TBL_MAX_W'(1);
        return (tbl >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// -----------------------------------------------------------------------------
// vend_stock_bank
// One down-counter per product. All counters load STOCK_INIT on reset; the
// selected counter decrements when a vend is accepted. A counter that has
// reached zero stays at zero and raises its empty flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   take_i       : a vend of product take_sel_i is being accepted this cycle
//   take_sel_i   : product index to decrement
//   empty_o      : one flag per product, high when that product's stock is 0
// -----------------------------------------------------------------------------
module vend_stock_bank
    import vending_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_INIT   = 3,
    parameter int SEL_W        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    take_i,
    input  logic [SEL_W-1:0]        take_sel_i,
    output logic [NUM_PRODUCTS-1:0] empty_o
);

    localparam int STOCK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];

    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_d[i] = stock_q[i];
            if (take_i && (take_sel_i == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (reset) begin
                stock_q[i] <= STOCK_LOAD;
            end else begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_empty
        assign empty_o[g] = (stock_q[g] == '0);
    end

endmodule

// File: rtl/vending_fsm_param.sv
// -----------------------------------------------------------------------------
// vending_fsm_param
// Vending controller: credit accumulator plus dispense/change sequencer in a
// single FSM (IDLE -> CREDIT -> VEND -> CHANGE -> IDLE).
// Optional feature: define STOCK_COUNT_EN to add per-product stock counters
// (vend_stock_bank) and the sold_out strobe; otherwise stock is unlimited and
// sold_out is tied low.
// Ports:
//   clk, reset     : prescaled clock, synchronous active-high reset
//   coin_valid     : one-cycle coin strobe, coin_value sampled with it
//   buy, sel       : purchase strobe and product index
//   cancel         : refund strobe
//   credit         : current credit
//   dispense       : high while the product is released
//   product        : last vended product index (held until the next vend)
//   change_valid   : one-cycle strobe, change_amount valid with it (else 0)
//   coin_reject    : one-cycle strobe, coin returned unaccepted
//   insufficient   : one-cycle strobe, buy refused (low credit / bad sel)
//   busy           : high in VEND or CHANGE
//   sold_out       : one-cycle strobe, buy refused for empty stock
// Handshake: every input is a single-cycle strobe with no ready; each strobe
// output is registered and appears exactly one cycle after its cause.
// -----------------------------------------------------------------------------
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int CREDIT_W        = 5,
    parameter int MAX_CREDIT      = 31,
    parameter int NUM_PRODUCTS    = 4,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_TABLE = {5'd7, 5'd5, 5'd3, 5'd2},
    parameter int DISPENSE_CYCLES = 2,
    parameter int STOCK_INIT      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            coin_valid,
    input  logic [CREDIT_W-1:0]             coin_value,
    input  logic                            buy,
    input  logic [$clog2(NUM_PRODUCTS)-1:0] sel,
    input  logic                            cancel,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            dispense,
    output logic [$clog2(NUM_PRODUCTS)-1:0] product,
    output logic                            change_valid,
    output logic [CREDIT_W-1:0]             change_amount,
    output logic                            coin_reject,
    output logic                            insufficient,
    output logic                            busy,
    output logic                            sold_out
);

    localparam int SEL_W = $clog2(NUM_PRODUCTS);
    localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    VEND_LAST      = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CREDIT_W:0]   MAX_CREDIT_EXT = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [PRICE_TBL_MAX_W-1:0] PRICE_TABLE_EXT =
        {{(PRICE_TBL_MAX_W - NUM_PRODUCTS * CREDIT_W){1'b0}}, PRICE_TABLE};

    if (NUM_PRODUCTS < 2 || DISPENSE_CYCLES < 1 || STOCK_INIT < 0 ||
        MAX_CREDIT > (2 ** CREDIT_W) - 1 ||
        NUM_PRODUCTS * CREDIT_W > PRICE_TBL_MAX_W) begin : g_bad_params
        $error("vending_fsm_param: illegal parameter set");
    end

    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [CREDIT_W-1:0]  price_q, price_d;
    logic [SEL_W-1:0]     product_q, product_d;
    logic [CNT_W-1:0]     vend_cnt_q, vend_cnt_d;
    logic                 dispense_q, dispense_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amount_q, change_amount_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 insufficient_q, insufficient_d;

    logic [CREDIT_W:0]        coin_sum;     // one spare bit so overflow is visible
    logic [PRICE_TBL_MAX_W-1:0] price_sel;
    logic [PRICE_TBL_MAX_W-1:0] credit_ext;
    logic                     sel_bad;
    logic                     take;         // purchase accepted this cycle

    assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
    assign price_sel  = price_at(PRICE_TABLE_EXT, int'(sel), CREDIT_W);
    assign credit_ext = {{(PRICE_TBL_MAX_W - CREDIT_W){1'b0}}, credit_q};

    // sel can only point past the table when NUM_PRODUCTS is not a power of 2.
    if ((1 << SEL_W) > NUM_PRODUCTS) begin : g_sel_range
        localparam logic [SEL_W:0] NUM_SEL_EXT = (SEL_W + 1)'(NUM_PRODUCTS);
        assign sel_bad = ({1'b0, sel} >= NUM_SEL_EXT);
    end else begin : g_sel_full
        assign sel_bad = 1'b0;
    end

`ifdef STOCK_COUNT_EN
    logic [NUM_PRODUCTS-1:0] stock_empty;
    logic                    sold_out_q, sold_out_d;

    vend_stock_bank #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .STOCK_INIT   (STOCK_INIT),
        .SEL_W        (SEL_W)
    ) u_stock (
        .clk        (clk),
        .reset      (reset),
        .take_i     (take),
        .take_sel_i (sel),
        .empty_o    (stock_empty)
    );
`endif

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        price_d         = price_q;
        product_d       = product_q;
        vend_cnt_d      = vend_cnt_q;
        dispense_d      = dispense_q;
        change_valid_d  = 1'b0;
        change_amount_d = '0;
        coin_reject_d   = 1'b0;
        insufficient_d  = 1'b0;
        take            = 1'b0;
`ifdef STOCK_COUNT_EN
        sold_out_d      = 1'b0;
`endif
        case (state_q)
            IDLE, CREDIT: begin
                // Priority: cancel > coin > buy. A coin that loses to cancel
                // is handed back; a buy that loses to anything is dropped.
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d         = CHANGE;
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= MAX_CREDIT_EXT) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = (coin_sum == '0) ? IDLE : CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (buy) begin
`ifdef STOCK_COUNT_EN
                    if (!sel_bad && stock_empty[sel]) begin
                        sold_out_d = 1'b1;
                    end else
`endif
                    if (sel_bad || (credit_ext < price_sel)) begin
                        insufficient_d = 1'b1;
                    end else begin
                        take       = 1'b1;
                        price_d    = price_sel[CREDIT_W-1:0];
                        product_d  = sel;
                        state_d    = VEND;
                        dispense_d = 1'b1;
                        vend_cnt_d = '0;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                if (vend_cnt_q == VEND_LAST) begin
                    dispense_d      = 1'b0;
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q - price_q;
                end else begin
                    vend_cnt_d = vend_cnt_q + 1'b1;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            price_q         <= '0;
            product_q       <= '0;
            vend_cnt_q      <= '0;
            dispense_q      <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            insufficient_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            price_q         <= price_d;
            product_q       <= product_d;
            vend_cnt_q      <= vend_cnt_d;
            dispense_q      <= dispense_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            insufficient_q  <= insufficient_d;
        end
    end

`ifdef STOCK_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sold_out_q <= 1'b0;
        end else begin
            sold_out_q <= sold_out_d;
        end
    end
    assign sold_out = sold_out_q;
`else
    assign sold_out = 1'b0;
`endif

    assign credit        = credit_q;
    assign dispense      = dispense_q;
    assign product       = product_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign coin_reject   = coin_reject_q;
    assign insufficient  = insufficient_q;
    assign busy          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_fsm_param.sv
module tb_vending_fsm_param;

  localparam int CW    = 5;
  localparam int MAXC  = 31;
  localparam int NP    = 4;
  localparam int DC    = 2;
  localparam int SINIT = 3;
  localparam int PRICES [NP] = '{2, 3, 5, 7};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          coin_valid;
  logic [CW-1:0] coin_value;
  logic          buy;
  logic [1:0]    sel;
  logic          cancel;
  logic [CW-1:0] credit;
  logic          dispense;
  logic [1:0]    product;
  logic          change_valid;
  logic [CW-1:0] change_amount;
  logic          coin_reject;
  logic          insufficient;
  logic          busy;
  logic          sold_out;

  vending_fsm_param #(
    .CREDIT_W        (CW),
    .MAX_CREDIT      (MAXC),
    .NUM_PRODUCTS    (NP),
    .PRICE_TABLE     ({5'd7, 5'd5, 5'd3, 5'd2}),
    .DISPENSE_CYCLES (DC),
    .STOCK_INIT      (SINIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .buy           (buy),
    .sel           (sel),
    .cancel        (cancel),
    .credit        (credit),
    .dispense      (dispense),
    .product       (product),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .coin_reject   (coin_reject),
    .insufficient  (insufficient),
    .busy          (busy),
    .sold_out      (sold_out)
  );

  int checks = 0;
  int errors = 0;

  // Output vector layout: credit, dispense, product, change_valid,
  // change_amount, coin_reject, insufficient, busy, sold_out.
  function automatic logic [17:0] pack_out(int cr, bit disp, int prod, bit chv,
                                           int amt, bit rej, bit ins, bit bsy, bit so);
    logic [4:0] cr5;
    logic [1:0] pr2;
    logic [4:0] am5;
    cr5 = cr[4:0];
    pr2 = prod[1:0];
    am5 = amt[4:0];
    return {cr5, disp, pr2, chv, am5, rej, ins, bsy, so};
  endfunction

  function automatic logic [17:0] dut_out();
    return {credit, dispense, product, change_valid, change_amount,
            coin_reject, insufficient, busy, sold_out};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic cv, input logic [4:0] cval,
                       input logic b, input logic [1:0] s, input logic c);
    reset      = rst;
    coin_valid = cv;
    coin_value = cval;
    buy        = b;
    sel        = s;
    cancel     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got cr=%0d disp=%0b prod=%0d chv=%0b amt=%0d rej=%0b ins=%0b busy=%0b so=%0b want cr=%0d disp=%0b prod=%0d chv=%0b amt=%0d rej=%0b ins=%0b busy=%0b so=%0b",
               name, act[17:13], act[12], act[11:10], act[9], act[8:4], act[3], act[2], act[1], act[0],
               exp[17:13], exp[12], exp[11:10], exp[9], exp[8:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        cv;
    logic [4:0]  cval;
    logic        b;
    logic [1:0]  s;
    logic        c;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Inputs, then expected outputs after the following clock edge.
  function automatic vec_t mkv(bit rst, bit cv, int cval, bit b, int s, bit c,
                               int cr, bit disp, int prod, bit chv, int amt,
                               bit rej, bit ins, bit bsy);
    vec_t v;
    logic [4:0] cv5;
    logic [1:0] s2;
    cv5    = cval[4:0];
    s2     = s[1:0];
    v.rst  = rst;
    v.cv   = cv;
    v.cval = cv5;
    v.b    = b;
    v.s    = s2;
    v.c    = c;
    v.exp  = pack_out(cr, disp, prod, chv, amt, rej, ins, bsy, 1'b0);
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // A purchase or refund is modelled as a script of future output cycles
  // queued up front; while the script plays the machine is busy.
  typedef struct {
    bit disp;
    bit chv;
    int amt;
  } slot_t;

  slot_t plan_q[$];
  int    m_credit;
  int    m_product;
  bit    m_busy;
  int    m_stock [NP];
  bit    e_disp, e_chv, e_rej, e_ins, e_so;
  int    e_amt;

  task automatic model_step(input bit rst, input bit cv, input int cval,
                            input bit b, input int s, input bit c);
    slot_t sl;
    e_disp = 0; e_chv = 0; e_rej = 0; e_ins = 0; e_so = 0; e_amt = 0;
    if (rst) begin
      plan_q.delete();
      m_credit  = 0;
      m_product = 0;
      m_busy    = 0;
      for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
      return;
    end
    if (m_busy) begin
      e_rej = cv;
      if (plan_q.size() == 0) begin
        m_credit = 0;
        m_busy   = 0;
      end
    end else if (c) begin
      e_rej = cv;
      if (m_credit > 0) plan_q.push_back('{disp: 0, chv: 1, amt: m_credit});
    end else if (cv) begin
      if (m_credit + cval <= MAXC) m_credit += cval;
      else e_rej = 1;
    end else if (b) begin
`ifdef STOCK_COUNT_EN
      if (s < NP && m_stock[s] == 0) e_so = 1;
      else
`endif
      if (s >= NP || m_credit < PRICES[s]) e_ins = 1;
      else begin
        m_product = s;
        m_stock[s]--;
        for (int k = 0; k < DC; k++) plan_q.push_back('{disp: 1, chv: 0, amt: 0});
        plan_q.push_back('{disp: 0, chv: 1, amt: m_credit - PRICES[s]});
      end
    end
    if (plan_q.size() > 0) begin
      sl     = plan_q.pop_front();
      e_disp = sl.disp;
      e_chv  = sl.chv;
      e_amt  = sl.amt;
      m_busy = 1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_value = '0; buy = 1'b0; sel = '0; cancel = 1'b0;

    //                 rst cv val b s c    cr disp prod chv amt rej ins busy
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0));
    // coins 2,1 then buy product 1 (price 3): exact change
    vecs.push_back(mkv(0, 1, 2, 0, 0, 0,   2, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 0,   3, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0,   3, 1, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0,  0, 0, 0));
    // coins 5,5 then buy product 3 (price 7): change 3
    vecs.push_back(mkv(0, 1, 5, 0, 0, 0,   5, 0, 1, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 0, 0, 0,  10, 0, 1, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 3, 0,  10, 1, 3, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  10, 1, 3, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  10, 0, 3, 1, 3,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // credit 2, buy product 2 (price 5) refused, then cancel refunds 2
    vecs.push_back(mkv(0, 1, 2, 0, 0, 0,   2, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 2, 0,   2, 0, 3, 0, 0,  0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   2, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,   2, 0, 3, 1, 2,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // overflow at 30+5, exact fill to 31, coin during VEND rejected
    vecs.push_back(mkv(0, 1, 30, 0, 0, 0, 30, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 0, 0, 0,  30, 0, 3, 0, 0,  1, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 0,  31, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 3, 0,  31, 1, 3, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 1, 4, 0, 0, 0,  31, 1, 3, 0, 0,  1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  31, 0, 3, 1, 24, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // cancel + coin 3 with credit 4: refund 4 and the coin is rejected
    vecs.push_back(mkv(0, 1, 4, 0, 0, 0,   4, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 1, 3, 0, 0, 1,   4, 0, 3, 1, 4,  1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // coin + buy collision drops the buy; zero coin is a no-op
    vecs.push_back(mkv(0, 1, 2, 1, 0, 0,   2, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0,   2, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,   2, 0, 3, 1, 2,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // cancel with zero credit ignored; buy with zero credit refused
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,   0, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0,   0, 0, 3, 0, 0,  0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0,   0, 0, 3, 0, 0,  0, 0, 0));
    // buy/cancel during VEND ignored; zero change still strobes
    vecs.push_back(mkv(0, 1, 3, 0, 0, 0,   3, 0, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0,   3, 1, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,   3, 1, 1, 0, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0,   3, 0, 1, 1, 0,  0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].cv, vecs[i].cval, vecs[i].b, vecs[i].s, vecs[i].c);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of a vend: everything clears, no change follows.
    drive(0, 1, 3, 0, 0, 0);
    check("rstvend_coin", pack_out(3, 0, 1, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 2, 0);
    check("rstvend_ins", pack_out(3, 0, 1, 0, 0, 0, 1, 0, 0));
    drive(0, 0, 0, 1, 1, 0);
    check("rstvend_buy", pack_out(3, 1, 1, 0, 0, 0, 0, 1, 0));
    drive(1, 0, 0, 0, 0, 0);
    check("rstvend_reset", pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    check("rstvend_after", pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    check("rstvend_quiet", pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef STOCK_COUNT_EN
    // Stock: three vends of product 0 empty it; the fourth buy is sold out.
    drive(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < SINIT; n++) begin
      drive(0, 1, 2, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      check($sformatf("stock_vend%0d", n), pack_out(2, 1, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < DC + 1; k++) drive(0, 0, 0, 0, 0, 0);
      check($sformatf("stock_done%0d", n), pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    drive(0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("stock_soldout", pack_out(2, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 0);
    check("stock_kept", pack_out(2, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

    // Randomized run against the reference model.
    model_step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("rand_reset", pack_out(m_credit, e_disp, m_product, e_chv, e_amt, e_rej, e_ins, m_busy, e_so));
    for (int t = 0; t < 4000; t++) begin
      bit r_rst, r_cv, r_b, r_c;
      int r_val, r_sel, r;
      r     = $urandom_range(0, 199);
      r_rst = (r == 0);
      r_c   = (r >= 1 && r < 10);
      r_cv  = ($urandom_range(0, 2) == 0);
      r_val = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      r_b   = ($urandom_range(0, 3) == 0);
      r_sel = $urandom_range(0, NP - 1);
      model_step(r_rst, r_cv, r_val, r_b, r_sel, r_c);
      drive(r_rst, r_cv, 5'(r_val), r_b, 2'(r_sel), r_c);
      check($sformatf("rand%0d", t),
            pack_out(m_credit, e_disp, m_product, e_chv, e_amt, e_rej, e_ins, m_busy, e_so));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
